// File: rtl/layer0_pkg.sv
// Shared types and constants for the layer-0 convolution sequencer.
package layer0_pkg;

    localparam int FP16_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_CHECK,
        ST_RESULT,
        ST_ERROR
    } sched_state_t;

    function automatic int calc_out_size(input int image_size, input int kernel_size);
        return image_size - kernel_size + 1;
    endfunction

    localparam int DEFAULT_OUT_SIZE = calc_out_size(28, 5);

endpackage

// File: rtl/sched_watchdog.sv
// Per-pass watchdog: loadable up-counter with clear and a sticky terminal count.
module sched_watchdog #(
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    // Counting stops at terminal count so tc stays high until cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/layer0_channel_scheduler.sv
// Layer-0 sequencer: runs the shared conv engine once per output channel and
// writes each output column to the feature-map buffer at ch*OUT_SIZE+col.
module layer0_channel_scheduler
    import layer0_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int IMAGE_SIZE  = 28,
    parameter int KERNEL_SIZE = 5,
    parameter int ADDR_W      = 12,
    parameter int TIMEOUT     = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_valid,
    output logic                      frame_ready,
    output logic                      eng_start,
    output logic [$clog2(NUM_CH)-1:0] eng_kernel_sel,
    input  logic                      eng_valid_col,
    input  logic                      eng_done,
    output logic                      col_we,
    output logic [ADDR_W-1:0]         col_addr,
    output logic                      res_valid,
    input  logic                      res_ready,
    input  logic                      abort,
    output logic                      busy,
    output logic                      err_timeout,
    output logic                      err_short,
    output logic                      err_overflow
);

    localparam int OUT_SIZE = calc_out_size(IMAGE_SIZE, KERNEL_SIZE);
    localparam int CH_W     = $clog2(NUM_CH);
    localparam int COL_W    = $clog2(OUT_SIZE + 1);

    generate
        if (NUM_CH * OUT_SIZE > (1 << ADDR_W)) begin : g_addr_range_check
            $error("layer0_channel_scheduler: NUM_CH*OUT_SIZE exceeds the ADDR_W address space");
        end
    endgenerate

    sched_state_t     state;
    logic [CH_W-1:0]  ch;
    logic [COL_W-1:0] col;
    logic             wdog_tc;
    logic             in_run;
    logic             last_ch;
    logic             col_room;
    logic             accept;
    logic             timeout_hit;

    assign in_run      = (state == ST_RUN);
    assign last_ch     = (ch == CH_W'(NUM_CH - 1));
    assign col_room    = (col < COL_W'(OUT_SIZE));
    assign accept      = (state == ST_IDLE) && frame_valid;
    assign timeout_hit = in_run && wdog_tc && !eng_done && !abort;

    sched_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == ST_START),
        .en       (in_run),
        .load     (1'b0),
        .load_val ('0),
        .tc       (wdog_tc)
    );

    // Abort wins over every other transition out of a non-idle state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (abort && (state != ST_IDLE)) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (frame_valid) state <= ST_START;
                ST_START:  state <= ST_RUN;
                ST_RUN: begin
                    if (eng_done)     state <= ST_CHECK;
                    else if (wdog_tc) state <= ST_ERROR;
                end
                ST_CHECK:  state <= last_ch ? ST_RESULT : ST_START;
                ST_RESULT: if (res_ready) state <= ST_IDLE;
                ST_ERROR:  state <= ST_ERROR;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Channel/column counters and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch           <= '0;
            col          <= '0;
            err_timeout  <= 1'b0;
            err_short    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (accept) begin
                ch           <= '0;
                err_timeout  <= 1'b0;
                err_short    <= 1'b0;
                err_overflow <= 1'b0;
            end
            if (state == ST_START && !abort) begin
                col <= '0;
            end
            if (in_run && eng_valid_col && !abort) begin
                if (col_room) col <= col + 1'b1;
                else          err_overflow <= 1'b1;
            end
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
            if (state == ST_CHECK && !abort) begin
                if (col != COL_W'(OUT_SIZE)) err_short <= 1'b1;
                if (!last_ch)                ch <= ch + 1'b1;
            end
        end
    end

    assign frame_ready    = (state == ST_IDLE) && !rst;
    assign busy           = (state != ST_IDLE);
    assign eng_start      = (state == ST_START);
    assign eng_kernel_sel = ch;
    assign res_valid      = (state == ST_RESULT);
    assign col_we         = in_run && eng_valid_col && col_room && !abort;
    assign col_addr       = ADDR_W'(ch) * ADDR_W'(OUT_SIZE) + ADDR_W'(col);

endmodule

// File: tb/tb_layer0_channel_scheduler.sv
// Directed bench for layer0_channel_scheduler with a queue-based write/kernel model.
module tb_layer0_channel_scheduler;

    localparam int NUM_CH      = 4;
    localparam int IMAGE_SIZE  = 28;
    localparam int KERNEL_SIZE = 5;
    localparam int ADDR_W      = 12;
    localparam int TIMEOUT     = 4096;
    localparam int OUT_SIZE    = IMAGE_SIZE - KERNEL_SIZE + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_valid = 1'b0;
    logic              frame_ready;
    logic              eng_start;
    logic [1:0]        eng_kernel_sel;
    logic              eng_valid_col;
    logic              eng_done;
    logic              col_we;
    logic [ADDR_W-1:0] col_addr;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic              abort = 1'b0;
    logic              busy;
    logic              err_timeout;
    logic              err_short;
    logic              err_overflow;

    layer0_channel_scheduler #(
        .NUM_CH      (NUM_CH),
        .IMAGE_SIZE  (IMAGE_SIZE),
        .KERNEL_SIZE (KERNEL_SIZE),
        .ADDR_W      (ADDR_W),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .eng_start      (eng_start),
        .eng_kernel_sel (eng_kernel_sel),
        .eng_valid_col  (eng_valid_col),
        .eng_done       (eng_done),
        .col_we         (col_we),
        .col_addr       (col_addr),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .abort          (abort),
        .busy           (busy),
        .err_timeout    (err_timeout),
        .err_short      (err_short),
        .err_overflow   (err_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model state: expected write addresses, expected kernel starts, expected flags.
    int exp_addr_q[$];
    int exp_kern_q[$];
    int obs_kern_q[$];
    bit exp_short, exp_over;
    int wr_count;
    int first_addr;
    int last_addr;
    int start_cyc[NUM_CH];
    int t_acc;

    always @(negedge clk) begin
        int a;
        int k;
        if (!rst) begin
            if (col_we) begin
                wr_count++;
                if (wr_count == 1) first_addr = int'(col_addr);
                last_addr = int'(col_addr);
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_write", col_addr, -1);
                end else begin
                    a = exp_addr_q.pop_front();
                    check("col_addr", col_addr, a);
                    check("kernel_during_write", eng_kernel_sel, a / OUT_SIZE);
                end
            end
            if (eng_start) begin
                obs_kern_q.push_back(int'(eng_kernel_sel));
                if (exp_kern_q.size() == 0) begin
                    check("unexpected_start", eng_kernel_sel, -1);
                end else begin
                    k = exp_kern_q.pop_front();
                    check("kernel_sel", eng_kernel_sel, k);
                    start_cyc[k] = cyc;
                end
            end
            if (res_valid) check("res_with_pending_writes", exp_addr_q.size(), 0);
        end
    end

    // Behavioural engine: per-channel column count, done with the last column.
    int eng_cols[NUM_CH];
    int eng_hang_ch = -1;
    bit eng_active = 1'b0;
    int eng_rem = 0;
    int eng_k = 0;

    initial begin
        eng_valid_col = 1'b0;
        eng_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            eng_valid_col = 1'b0;
            eng_done = 1'b0;
            if (rst) begin
                eng_active = 1'b0;
            end else if (eng_start) begin
                eng_active = 1'b1;
                eng_k = int'(eng_kernel_sel);
                eng_rem = eng_cols[eng_k];
            end else if (eng_active) begin
                if (eng_rem > 0) begin
                    eng_valid_col = 1'b1;
                    eng_rem--;
                end
                if (eng_rem == 0 && eng_k != eng_hang_ch) begin
                    eng_done = 1'b1;
                    eng_active = 1'b0;
                end
            end
        end
    end

    task automatic start_frame(input int c0, input int c1, input int c2, input int c3, input int hang);
        int n;
        int nw;
        eng_cols = '{c0, c1, c2, c3};
        eng_hang_ch = hang;
        exp_addr_q.delete();
        exp_kern_q.delete();
        obs_kern_q.delete();
        exp_short = 1'b0;
        exp_over = 1'b0;
        wr_count = 0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (hang >= 0 && ch > hang) break;
            exp_kern_q.push_back(ch);
            nw = (eng_cols[ch] < OUT_SIZE) ? eng_cols[ch] : OUT_SIZE;
            for (int c = 0; c < nw; c++) exp_addr_q.push_back(ch * OUT_SIZE + c);
            if (eng_cols[ch] > OUT_SIZE) exp_over = 1'b1;
            if (eng_cols[ch] < OUT_SIZE && ch != hang) exp_short = 1'b1;
        end
        n = 0;
        while (!frame_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("frame_ready_before_accept", frame_ready, 1);
        frame_valid = 1'b1;
        t_acc = cyc;
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        check("eng_start_after_accept", eng_start, 1);
        check("busy_after_accept", busy, 1);
        check("flags_cleared_on_accept", {err_timeout, err_short, err_overflow}, 0);
    endtask

    task automatic finish_frame(input int hold, output int res_cyc);
        int n;
        n = 0;
        while (!res_valid && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("res_valid_reached", res_valid, 1);
        res_cyc = cyc;
        check("writes_outstanding", exp_addr_q.size(), 0);
        check("err_short", err_short, exp_short);
        check("err_overflow", err_overflow, exp_over);
        check("err_timeout", err_timeout, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_res_valid", res_valid, 1);
            check("bp_frame_ready", frame_ready, 0);
            check("bp_col_we", col_we, 0);
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        check("idle_after_res_frame_ready", frame_ready, 1);
        check("idle_after_res_valid", res_valid, 0);
        check("idle_after_res_busy", busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rc;
        int n;
        #2;
        check("rst_frame_ready", frame_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_eng_start", eng_start, 0);
        check("rst_col_we", col_we, 0);
        check("rst_col_addr", col_addr, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_flags", {err_timeout, err_short, err_overflow}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_frame_ready", frame_ready, 1);
        @(posedge clk);
        #1;

        // Nominal frame: 96 writes, kernels 0..3, fixed latency for 24-column passes.
        start_frame(24, 24, 24, 24, -1);
        finish_frame(0, rc);
        check("nominal_latency", rc - t_acc, 105);
        check("nominal_write_count", wr_count, 96);
        check("nominal_first_addr", first_addr, 0);
        check("nominal_last_addr", last_addr, 95);
        check("nominal_start_count", obs_kern_q.size(), 4);
        for (int i = 0; i < obs_kern_q.size(); i++) check("nominal_kernel_order", obs_kern_q[i], i);

        // Short pass on ch1.
        start_frame(24, 22, 24, 24, -1);
        finish_frame(0, rc);
        check("short_write_count", wr_count, 94);
        check("short_last_addr", last_addr, 95);

        // Overflow on ch0.
        start_frame(26, 24, 24, 24, -1);
        finish_frame(0, rc);
        check("overflow_write_count", wr_count, 96);

        // Result backpressure for 10 cycles.
        start_frame(24, 24, 24, 24, -1);
        finish_frame(10, rc);

        // Timeout: ch2 never signals done.
        start_frame(24, 24, 24, 24, 2);
        n = 0;
        while (!err_timeout && n < TIMEOUT + 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("timeout_flag", err_timeout, 1);
        check("timeout_latency", cyc - start_cyc[2], TIMEOUT + 1);
        check("timeout_writes", wr_count, 72);
        repeat (3) @(posedge clk);
        #1;
        check("error_busy", busy, 1);
        check("error_frame_ready", frame_ready, 0);
        check("error_res_valid", res_valid, 0);
        check("error_other_flags", {err_short, err_overflow}, 0);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_frame_ready", frame_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_keeps_timeout", err_timeout, 1);

        // Reset mid-RUN at ch1 col7.
        start_frame(24, 24, 24, 24, -1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(col_we && col_addr == ADDR_W'(31)) && n < 500);
        check("reached_ch1_col7", col_addr, 31);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_frame_ready", frame_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_col_we", col_we, 0);
        check("midrst_col_addr", col_addr, 0);
        check("midrst_kernel_sel", eng_kernel_sel, 0);
        check("midrst_eng_start", eng_start, 0);
        check("midrst_res_valid", res_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_addr_q.delete();
        exp_kern_q.delete();
        start_frame(24, 24, 24, 24, -1);
        finish_frame(0, rc);
        check("after_rst_first_addr", first_addr, 0);
        check("after_rst_write_count", wr_count, 96);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

endmodule
